// File: rtl/ifetch_if.sv
// Instruction-fetch bus bundle: imem request/response, branch redirect and decode handshake.
// The IFETCH_PERF_EN macro adds the perf_fetch_o/perf_stall_o counter outputs.
interface ifetch_if #(
    parameter int WORD = 32
);
    logic            imem_req_o;
    logic [WORD-1:0] imem_addr_o;
    logic            imem_ack_i;
    logic [WORD-1:0] imem_rdata_i;
    logic            br_i;
    logic [WORD-1:0] br_addr_i;
    logic            v_o;
    logic [WORD-1:0] inst_o;
    logic [WORD-1:0] pc_o;
    logic            stall_i;
`ifdef IFETCH_PERF_EN
    logic [WORD-1:0] perf_fetch_o;
    logic [WORD-1:0] perf_stall_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_ack_i, imem_rdata_i,
        input  br_i, br_addr_i,
        output v_o, inst_o, pc_o,
        input  stall_i,
        output perf_fetch_o, perf_stall_o
    );
    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_ack_i, imem_rdata_i,
        output br_i, br_addr_i,
        input  v_o, inst_o, pc_o,
        output stall_i,
        input  perf_fetch_o, perf_stall_o
    );
`else
    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_ack_i, imem_rdata_i,
        input  br_i, br_addr_i,
        output v_o, inst_o, pc_o,
        input  stall_i
    );
    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_ack_i, imem_rdata_i,
        output br_i, br_addr_i,
        input  v_o, inst_o, pc_o,
        output stall_i
    );
`endif
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: PC owner, single-outstanding imem requester, 1-entry skid, branch flush.
// Optional IFETCH_PERF_EN adds fetch/stall event counters.
module ifetch #(
    parameter int              WORD     = 32,
    parameter logic [WORD-1:0] RESET_PC = '0,
    parameter logic [WORD-1:0] PC_INC   = 4
) (
    input logic     clk,
    input logic     rst,
    ifetch_if.master bus
);

    typedef enum logic [1:0] {RUN, BLOCK, DRAIN} state_t;

    state_t          state, state_nx;
    logic [WORD-1:0] pc_r, pc_nx;
    logic [WORD-1:0] tgt_r, tgt_nx;
    logic            vld_p1, vld_nx;
    logic [WORD-1:0] inst_p1, inst_nx;
    logic [WORD-1:0] pc_p1, pc_out_nx;
    logic            skid_vld, skid_vld_nx;
    logic [WORD-1:0] skid_inst, skid_inst_nx;
    logic [WORD-1:0] skid_pc, skid_pc_nx;
    logic            req, ack, keep, out_free;

    // Request is gated by reset so an in-flight transaction is simply dropped.
    assign req      = (((state == RUN) && !skid_vld) || (state == DRAIN)) && !rst;
    assign ack      = req && bus.imem_ack_i;
    assign keep     = ack && (state == RUN) && !bus.br_i;
    assign out_free = !vld_p1 || !bus.stall_i;

    always_comb begin
        state_nx     = state;
        pc_nx        = pc_r;
        tgt_nx       = tgt_r;
        vld_nx       = vld_p1;
        inst_nx      = inst_p1;
        pc_out_nx    = pc_p1;
        skid_vld_nx  = skid_vld;
        skid_inst_nx = skid_inst;
        skid_pc_nx   = skid_pc;

        if (out_free) begin
            if (skid_vld) begin
                vld_nx      = 1'b1;
                inst_nx     = skid_inst;
                pc_out_nx   = skid_pc;
                skid_vld_nx = 1'b0;
            end else if (keep) begin
                vld_nx    = 1'b1;
                inst_nx   = bus.imem_rdata_i;
                pc_out_nx = pc_r;
            end else begin
                vld_nx = 1'b0;
            end
        end
        if (keep && !(out_free && !skid_vld)) begin
            skid_vld_nx  = 1'b1;
            skid_inst_nx = bus.imem_rdata_i;
            skid_pc_nx   = pc_r;
        end

        case (state)
            RUN: begin
                if (ack) pc_nx = pc_r + PC_INC;
                if (skid_vld_nx) state_nx = BLOCK;
            end
            BLOCK: begin
                if (out_free) state_nx = RUN;
            end
            DRAIN: begin
                if (ack) begin
                    pc_nx    = tgt_r;
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase

        // Redirect overrides everything: flush both output slots and retarget.
        if (bus.br_i) begin
            vld_nx      = 1'b0;
            skid_vld_nx = 1'b0;
            case (state)
                RUN: begin
                    if (req && !ack) begin
                        tgt_nx   = bus.br_addr_i;
                        pc_nx    = pc_r;
                        state_nx = DRAIN;
                    end else begin
                        pc_nx    = bus.br_addr_i;
                        state_nx = RUN;
                    end
                end
                DRAIN: begin
                    tgt_nx = bus.br_addr_i;
                    if (ack) begin
                        pc_nx    = bus.br_addr_i;
                        state_nx = RUN;
                    end
                end
                default: begin
                    pc_nx    = bus.br_addr_i;
                    state_nx = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc_r     <= RESET_PC;
            vld_p1   <= 1'b0;
            inst_p1  <= '0;
            pc_p1    <= '0;
            skid_vld <= 1'b0;
        end else begin
            state    <= state_nx;
            pc_r     <= pc_nx;
            vld_p1   <= vld_nx;
            inst_p1  <= inst_nx;
            pc_p1    <= pc_out_nx;
            skid_vld <= skid_vld_nx;
        end
    end

    always_ff @(posedge clk) begin
        tgt_r     <= tgt_nx;
        skid_inst <= skid_inst_nx;
        skid_pc   <= skid_pc_nx;
    end

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = pc_r;
    assign bus.v_o         = vld_p1;
    assign bus.inst_o      = inst_p1;
    assign bus.pc_o        = pc_p1;

`ifdef IFETCH_PERF_EN
    logic [WORD-1:0] perf_fetch, perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else begin
            if (keep) perf_fetch <= perf_fetch + 1'b1;
            if (vld_p1 && bus.stall_i) perf_stall <= perf_stall + 1'b1;
        end
    end

    assign bus.perf_fetch_o = perf_fetch;
    assign bus.perf_stall_o = perf_stall;
`endif

endmodule
